// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vend states, error codes and product codes
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_WAIT_SEL,
    ST_CHECK,
    ST_DISPENSE,
    ST_WAIT_DISP,
    ST_DONE,
    ST_ERROR
  } vend_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_INVALID = 2'b01;
  localparam logic [1:0] ERR_CREDIT  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [1:0] PRODUCT_NONE = 2'b00;
  localparam logic [1:0] PRODUCT_A    = 2'b01;
  localparam logic [1:0] PRODUCT_B    = 2'b10;
  localparam logic [1:0] PRODUCT_C    = 2'b11;

  // Strobe cycles count as the first cycle of their wait window, so they are
  // grouped with the explicit wait states for done sampling and timing.
  function automatic logic is_wait_state(input vend_state_e s);
    return (s == ST_SELECT) || (s == ST_WAIT_SEL) ||
           (s == ST_DISPENSE) || (s == ST_WAIT_DISP);
  endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// rtl/vend_timeout_timer.sv - load/expire down-counter bounding each responder wait
module vend_timeout_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Load counts the first window cycle already, so expiry lands on cycle TIMEOUT_CYC
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(TIMEOUT_CYC - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - product-selector handshake initiator; VEND_SEQ_STATS_EN adds vend/err counters
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int SEL_W       = 2,
  parameter int PRICE_W     = 5,
  parameter int TIMEOUT_CYC = 16
`ifdef VEND_SEQ_STATS_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [SEL_W-1:0]   req_sel,
  output logic               req_ready,
  input  logic [PRICE_W-1:0] credit,
  output logic [SEL_W-1:0]   product_sel,
  output logic               signal_product_selector,
  input  logic [PRICE_W-1:0] product_price,
  input  logic               product_selector_done,
  output logic               product_dispense_en,
  input  logic               product_dispense_done,
  output logic               change_valid,
  output logic [PRICE_W-1:0] change_amt,
  output logic               credit_clear,
  output logic               err_valid,
  output logic [1:0]         err_code
`ifdef VEND_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0]   vend_count,
  output logic [7:0]         err_count
`endif
);

  vend_state_e        state_q, state_d;
  logic [SEL_W-1:0]   product_sel_q, product_sel_d;
  logic [PRICE_W-1:0] price_q, price_d;
  logic [PRICE_W-1:0] change_amt_q, change_amt_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               req_ready_q, sel_strobe_q, dispense_en_q;
  logic               change_valid_q, err_valid_q;
  logic               req_ready_d, sel_strobe_d, dispense_en_d;
  logic               change_valid_d, err_valid_d;
  logic               timer_load, timer_en, timer_expired;

  vend_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (timer_en),
    .expired(timer_expired)
  );

  // Next-state and latched transaction data; done beats expiry in the same cycle
  always_comb begin
    state_d       = state_q;
    product_sel_d = product_sel_q;
    price_d       = price_q;
    change_amt_d  = change_amt_q;
    err_code_d    = err_code_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          product_sel_d = req_sel;
          err_code_d    = ERR_NONE;
          state_d       = ST_SELECT;
        end
      end
      ST_SELECT, ST_WAIT_SEL: begin
        if (product_selector_done) begin
          price_d = product_price;
          state_d = ST_CHECK;
        end else if (timer_expired) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_ERROR;
        end else begin
          state_d = ST_WAIT_SEL;
        end
      end
      ST_CHECK: begin
        if ((price_q == '0) || (product_sel_q == SEL_W'(PRODUCT_NONE))) begin
          err_code_d = ERR_INVALID;
          state_d    = ST_ERROR;
        end else if (credit < price_q) begin
          err_code_d = ERR_CREDIT;
          state_d    = ST_ERROR;
        end else begin
          change_amt_d = credit - price_q;
          state_d      = ST_DISPENSE;
        end
      end
      ST_DISPENSE, ST_WAIT_DISP: begin
        if (product_dispense_done) begin
          state_d = ST_DONE;
        end else if (timer_expired) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_ERROR;
        end else begin
          state_d = ST_WAIT_DISP;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they align with it
  always_comb begin
    req_ready_d    = (state_d == ST_IDLE);
    sel_strobe_d   = (state_d == ST_SELECT);
    dispense_en_d  = (state_d == ST_DISPENSE);
    change_valid_d = (state_d == ST_DONE);
    err_valid_d    = (state_d == ST_ERROR);
    timer_load     = (state_d == ST_SELECT) || (state_d == ST_DISPENSE);
    timer_en       = is_wait_state(state_q);
  end

  // State and output registers; reset drops any transaction without reporting it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      product_sel_q  <= '0;
      price_q        <= '0;
      change_amt_q   <= '0;
      err_code_q     <= ERR_NONE;
      req_ready_q    <= 1'b1;
      sel_strobe_q   <= 1'b0;
      dispense_en_q  <= 1'b0;
      change_valid_q <= 1'b0;
      err_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      product_sel_q  <= product_sel_d;
      price_q        <= price_d;
      change_amt_q   <= change_amt_d;
      err_code_q     <= err_code_d;
      req_ready_q    <= req_ready_d;
      sel_strobe_q   <= sel_strobe_d;
      dispense_en_q  <= dispense_en_d;
      change_valid_q <= change_valid_d;
      err_valid_q    <= err_valid_d;
    end
  end

  assign req_ready               = req_ready_q;
  assign product_sel             = product_sel_q;
  assign signal_product_selector = sel_strobe_q;
  assign product_dispense_en     = dispense_en_q;
  assign change_valid            = change_valid_q;
  assign change_amt              = change_amt_q;
  assign credit_clear            = change_valid_q;
  assign err_valid               = err_valid_q;
  assign err_code                = err_code_q;

`ifdef VEND_SEQ_STATS_EN
  logic [CNT_W-1:0] vend_count_q, vend_count_d;
  logic [7:0]       err_count_q, err_count_d;

  // Saturating counters step alongside the completion and error strobes
  always_comb begin
    vend_count_d = vend_count_q;
    err_count_d  = err_count_q;
    if (change_valid_d && (vend_count_q != '1)) begin
      vend_count_d = vend_count_q + CNT_W'(1);
    end
    if (err_valid_d && (err_count_q != '1)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vend_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      vend_count_q <= vend_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign vend_count = vend_count_q;
  assign err_count  = err_count_q;
`endif

endmodule
